// File: rtl/piso_pkg.sv
// piso_pkg: shared width default and FSM state encoding for piso_tx
package piso_pkg;
  localparam int WIDTH_DEF = 4;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
endpackage

// File: rtl/piso_tx_if.sv
// piso_tx_if: load handshake and serial output bundle of piso_tx
// master drives pi/load_valid and observes the rest; slave is the transmitter.
interface piso_tx_if #(parameter int WIDTH = piso_pkg::WIDTH_DEF) ();
  logic [WIDTH-1:0] pi;
  logic             load_valid;
  logic             load_ready;
  logic             so;
  logic             so_valid;
  logic             last;
  logic             busy;
  modport master (output pi, load_valid, input load_ready, so, so_valid, last, busy);
  modport slave  (input pi, load_valid, output load_ready, so, so_valid, last, busy);
endinterface

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, MSB first, one-word holding buffer
// Ports: clk (rising edge), rst_n (async active-low), bus (piso_tx_if.slave):
//   pi/load_valid/load_ready load handshake, so/so_valid/last serial stream, busy.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic       clk,
  input logic       rst_n,
  piso_tx_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_shreg, r_hold;
  logic             r_hold_full;
  logic [CW-1:0]    r_cnt;
  logic             w_accept, w_end;
  assign w_accept = bus.load_valid && !r_hold_full;
  assign w_end    = (r_state == SHIFT) && (r_cnt == CW'(WIDTH - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // Stay in SHIFT across a word boundary whenever another word is available.
  always_comb
    w_next = (r_state == IDLE) ? (w_accept ? SHIFT : IDLE)
           : (w_end && !r_hold_full && !w_accept) ? IDLE : SHIFT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_shreg     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_cnt       <= '0;
    end else if (r_state == IDLE) begin
      if (w_accept) begin
        r_shreg <= bus.pi;
        r_cnt   <= '0;
      end
    end else if (w_end) begin
      r_cnt <= '0;
      if (r_hold_full) begin
        r_shreg     <= r_hold;
        r_hold_full <= 1'b0;
      end else
        r_shreg <= w_accept ? bus.pi : {r_shreg[WIDTH-2:0], 1'b0};
    end else begin
      r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
      r_cnt   <= r_cnt + CW'(1);
      if (w_accept) begin
        r_hold      <= bus.pi;
        r_hold_full <= 1'b1;
      end
    end
  always_comb begin
    bus.so         = (r_state == SHIFT) && r_shreg[WIDTH-1];
    bus.so_valid   = (r_state == SHIFT);
    bus.last       = w_end;
    bus.busy       = (r_state == SHIFT) || r_hold_full;
    bus.load_ready = !r_hold_full;
  end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: scoreboard bench for piso_tx with directed and random traffic
module tb_piso_tx;
  import piso_pkg::*;
  localparam int W = WIDTH_DEF;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  piso_tx_if #(.WIDTH(W)) bus ();
  piso_tx #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_tests = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask
  task automatic out(input string name, input logic v, input logic s, input logic l);
    chk(name, {bus.so_valid, bus.so, bus.last}, {v, s, l});
  endtask
  // Drive one cycle; a word is expected on the wire iff it is accepted at the coming edge.
  task automatic cycle(input logic v, input logic [W-1:0] d);
    bus.load_valid = v;
    bus.pi = d;
    if (rst_n && v && bus.load_ready) exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask
  task automatic drain(input string name);
    int k;
    k = 0;
    bus.load_valid = 1'b0;
    while ((exp_q.size() != 0 || bus.busy) && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({name, "_drain_q"}, exp_q.size(), 0);
    chk({name, "_drain_busy"}, bus.busy, 0);
  endtask
  // Monitor: SIPO capture gated by so_valid, compared with the scoreboard on last.
  initial begin
    logic [W-1:0] cap;
    int nb;
    cap = '0;
    nb = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) nb = 0;
      else if (bus.so_valid) begin
        cap = {cap[W-2:0], bus.so};
        nb++;
        if (bus.last) begin
          chk("last_position", nb, W);
          if (exp_q.size() == 0) chk("unexpected_word", cap, 'x);
          else chk("loopback_word", cap, exp_q.pop_front());
          nb = 0;
        end else if (nb >= W) begin
          chk("last_missing", bus.last, 1);
          nb = 0;
        end
      end else begin
        chk("idle_outputs", {bus.so, bus.last}, 0);
        if (nb != 0) begin
          chk("gap_mid_word", nb, 0);
          nb = 0;
        end
      end
    end
  end
  initial begin
    logic [7:0] s;
    int acc, guard;
    logic v;
    bus.load_valid = 1'b1;
    bus.pi = 4'b0101;
    repeat (3) begin
      @(posedge clk);
      #1;
      bus.pi = W'($urandom);
    end
    out("reset_out", 0, 0, 0);
    chk("reset_ready", bus.load_ready, 1);
    chk("reset_busy", bus.busy, 0);
    rst_n = 1'b1;
    #1;
    chk("release_busy", bus.busy, 0);
    cycle(1, 4'b1101);
    chk("single_busy", bus.busy, 1);
    out("single_b0", 1, 1, 0);
    cycle(0, W'($urandom));
    out("single_b1", 1, 1, 0);
    cycle(0, W'($urandom));
    out("single_b2", 1, 0, 0);
    cycle(0, W'($urandom));
    out("single_b3", 1, 1, 1);
    cycle(0, W'($urandom));
    out("single_idle", 0, 0, 0);
    chk("single_idle_busy", bus.busy, 0);
    s = 8'b11010110;
    cycle(1, 4'b1101);
    out("b2b_bit7", 1, s[7], 0);
    cycle(1, 4'b0110);
    chk("b2b_ready_hold", bus.load_ready, 0);
    out("b2b_bit6", 1, s[6], 0);
    for (int i = 5; i >= 0; i--) begin
      cycle(0, W'($urandom));
      out($sformatf("b2b_bit%0d", i), 1, s[i], (i == 4) || (i == 0));
      chk($sformatf("b2b_ready%0d", i), bus.load_ready, i <= 3);
    end
    cycle(0, W'($urandom));
    out("b2b_idle", 0, 0, 0);
    for (int i = 0; i < 14; i++) cycle(1, W'($urandom));
    drain("backpressure");
    cycle(1, 4'b1011);
    cycle(1, 4'b0110);
    chk("midreset_held", bus.load_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    out("midreset_out", 0, 0, 0);
    chk("midreset_ready", bus.load_ready, 1);
    chk("midreset_busy", bus.busy, 0);
    exp_q.delete();
    bus.load_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(0, W'($urandom));
      chk($sformatf("postreset_quiet%0d", i), bus.so_valid, 0);
    end
    acc = 0;
    guard = 0;
    while (acc < 100 && guard < 5000) begin
      v = ($urandom_range(0, 3) != 0);
      if (v && bus.load_ready) acc++;
      cycle(v, W'($urandom));
      guard++;
    end
    chk("random_accepts", acc, 100);
    drain("random");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
